// File: rtl/bin_to_bcd_converter.sv
// Sequential 16-bit binary to 4-digit BCD converter (double-dabble, one bit per cycle)
// with overflow detection and optional leading-zero blanking for a 7-segment display.
module bin_to_bcd_converter #(
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] bin_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [15:0] bcd_o,
    output logic        done_o,
    output logic        ovf_o
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FORMAT} state_t;

    localparam logic [15:0] BCD_RST = BLANK_LEAD ? 16'hFFF0 : 16'h0000;

    state_t      r_state, w_next;
    logic [15:0] r_bin;
    logic [19:0] r_scratch;
    logic [3:0]  r_cnt;
    logic [15:0] r_bcd;
    logic        r_done;
    logic        r_ovf;

    logic [19:0] w_adj;
    logic [15:0] w_fmt;
    logic        w_ovf;

    assign ready_o = (r_state == S_IDLE);
    assign bcd_o   = r_bcd;
    assign done_o  = r_done;
    assign ovf_o   = r_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (valid_i) w_next = S_SHIFT;
            S_SHIFT:  if (r_cnt == 4'd15) w_next = S_FORMAT;
            S_FORMAT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Add-3 correction on every digit before the shift
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < 5; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
    end

    // Digit 0 always shows; higher digits blank only while everything above is zero too
    always_comb begin
        w_ovf = (r_scratch[19:16] != 4'd0);
        w_fmt = r_scratch[15:0];
        if (w_ovf) begin
            w_fmt = 16'hFFFF;
        end else if (BLANK_LEAD && r_scratch[15:12] == 4'd0) begin
            w_fmt[15:12] = 4'hF;
            if (r_scratch[11:8] == 4'd0) begin
                w_fmt[11:8] = 4'hF;
                if (r_scratch[7:4] == 4'd0)
                    w_fmt[7:4] = 4'hF;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= BCD_RST;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_bin     <= bin_i;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                    end
                end
                S_SHIFT: begin
                    r_scratch <= {w_adj[18:0], r_bin[15]};
                    r_bin     <= {r_bin[14:0], 1'b0};
                    r_cnt     <= r_cnt + 4'd1;
                end
                S_FORMAT: begin
                    r_bcd  <= w_fmt;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: a vector table plus hand-written
// back-to-back and reset-abort sequences; one instance per BLANK_LEAD setting.
module tb_bin_to_bcd_converter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] bin_i;
    logic        valid_i;
    logic        ready_o, done_o, ovf_o;
    logic [15:0] bcd_o;
    logic        ready0, done0, ovf0;
    logic [15:0] bcd0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    bin_to_bcd_converter #(.BLANK_LEAD(1'b1)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .bin_i(bin_i), .valid_i(valid_i),
        .ready_o(ready_o), .bcd_o(bcd_o), .done_o(done_o), .ovf_o(ovf_o));

    bin_to_bcd_converter #(.BLANK_LEAD(1'b0)) u_dut0 (
        .clk_i(clk_i), .rst_i(rst_i), .bin_i(bin_i), .valid_i(valid_i),
        .ready_o(ready0), .bcd_o(bcd0), .done_o(done0), .ovf_o(ovf0));

    typedef struct {
        logic [15:0] bin;
        logic [15:0] bcd_bl;
        logic        ovf;
        logic [15:0] bcd_nb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single request; checks latency, ready/done behaviour, output hold and result
    task automatic convert(input vec_t v);
        int          k;
        int          busy;
        logic        held;
        logic [15:0] prev;
        prev = bcd_o;
        held = 1'b1;
        busy = 0;
        k    = 0;
        while (!ready_o && k < 40) begin @(negedge clk_i); k++; end
        bin_i   = v.bin;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        bin_i   = 16'hDEAD;
        k = 0;
        while (!done_o && k < 40) begin
            if (!ready_o) busy++;
            if (bcd_o !== prev) held = 1'b0;
            @(negedge clk_i);
            k++;
        end
        chk($sformatf("latency_%0d", v.bin), k, 17);
        chk($sformatf("busy_%0d", v.bin), busy, 17);
        chk($sformatf("hold_%0d", v.bin), held, 1);
        chk($sformatf("ready_at_done_%0d", v.bin), ready_o, 1);
        chk($sformatf("bcd_%0d", v.bin), bcd_o, v.bcd_bl);
        chk($sformatf("ovf_%0d", v.bin), ovf_o, v.ovf);
        chk($sformatf("bcd_nb_%0d", v.bin), bcd0, v.bcd_nb);
        @(negedge clk_i);
        chk($sformatf("done_one_cycle_%0d", v.bin), done_o, 0);
    endtask

    initial begin
        int   k;
        int   dones;
        vec_t v;

        vecs[0] = '{16'd1234,  16'h1234, 1'b0, 16'h1234};
        vecs[1] = '{16'd0,     16'hFFF0, 1'b0, 16'h0000};
        vecs[2] = '{16'd42,    16'hFF42, 1'b0, 16'h0042};
        vecs[3] = '{16'd1005,  16'h1005, 1'b0, 16'h1005};
        vecs[4] = '{16'd9999,  16'h9999, 1'b0, 16'h9999};
        vecs[5] = '{16'd10000, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[6] = '{16'd65535, 16'hFFFF, 1'b1, 16'hFFFF};
        vecs[7] = '{16'd7,     16'hFFF7, 1'b0, 16'h0007};
        vecs[8] = '{16'd100,   16'hF100, 1'b0, 16'h0100};

        rst_i = 1'b1; valid_i = 1'b0; bin_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (5) @(negedge clk_i);
        chk("rst_ready", ready_o, 1);
        chk("rst_bcd", bcd_o, 16'hFFF0);
        chk("rst_bcd_nb", bcd0, 16'h0000);
        chk("rst_done", done_o, 0);
        chk("rst_ovf", ovf_o, 0);

        foreach (vecs[i]) convert(vecs[i]);

        // Back-to-back: valid held, bin changes mid-conversion
        bin_i = 16'd1234; valid_i = 1'b1;
        @(negedge clk_i);
        bin_i = 16'd5678;
        k = 0;
        while (!done_o && k < 40) begin @(negedge clk_i); k++; end
        chk("b2b_first_bcd", bcd_o, 16'h1234);
        chk("b2b_ready_at_done", ready_o, 1);
        k = 0;
        do begin @(negedge clk_i); k++; end while (!done_o && k < 40);
        valid_i = 1'b0;
        chk("b2b_spacing", k, 18);
        chk("b2b_second_bcd", bcd_o, 16'h5678);
        @(negedge clk_i);

        // Reset 8 cycles after acceptance aborts the conversion
        bin_i = 16'd4321; valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (7) @(negedge clk_i);
        chk("abort_busy", ready_o, 0);
        rst_i = 1'b1;
        #1;
        chk("abort_async_ready", ready_o, 1);
        chk("abort_bcd", bcd_o, 16'hFFF0);
        chk("abort_ovf", ovf_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_ready_after", ready_o, 1);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) dones++;
            @(negedge clk_i);
        end
        chk("abort_no_done", dones, 0);
        v = '{16'd2468, 16'h2468, 1'b0, 16'h2468};
        convert(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_converter.md
BIN_TO_BCD_CONVERTER -- requirements
Module: bin_to_bcd_converter

Interface
REQ-001 SHALL have parameter BLANK_LEAD, default 1: 1 = replace leading zero digits with 4'hF (display off code), 0 = no blanking.
REQ-002 SHALL have port clk_i, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port bin_i, input, 16, unsigned binary value to convert; sampled only on acceptance.
REQ-005 SHALL have port valid_i, input, 1, request strobe qualifying bin_i.
REQ-006 SHALL have port ready_o, output, 1, high when a new request can be accepted.
REQ-007 SHALL have port bcd_o, output, 16, four packed BCD digits, [15:12] most significant; feeds the display controller's 16-bit number input.
REQ-008 SHALL have port done_o, output, 1, one-cycle pulse when bcd_o/ovf_o update.
REQ-009 SHALL have port ovf_o, output, 1, last converted value exceeded 9999.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, FORMAT.
REQ-011 ready_o SHALL be 1 exactly when state is IDLE, combinationally from state.
REQ-012 Acceptance SHALL occur on an edge where valid_i=1 and ready_o=1: capture bin_i, clear 20-bit scratch (5 digits), load shift counter with 0, go to SHIFT.
REQ-013 valid_i while not IDLE SHALL be ignored; no queuing.
REQ-014 In SHIFT, each cycle SHALL apply double-dabble: add 3 to every scratch digit >=5, then shift {scratch, bin} left by 1.
REQ-015 SHIFT SHALL last exactly 16 cycles (counter 0..15), then go to FORMAT.
REQ-016 In FORMAT (one cycle) SHALL: set ovf_o = (digit4 != 0); compute bcd_o; pulse done_o; go to IDLE.
REQ-017 On overflow bcd_o SHALL be 16'hFFFF (all digits off), regardless of BLANK_LEAD.
REQ-018 With no overflow and BLANK_LEAD=0, bcd_o SHALL be scratch digits 3..0.
REQ-019 With no overflow and BLANK_LEAD=1, digits 3..1 SHALL be replaced by 4'hF while they and all more-significant digits are 0; digit 0 SHALL never be blanked.
REQ-020 Latency: acceptance edge E0; bcd_o, ovf_o updated and done_o high in the cycle following edge E17; ready_o high again in that same cycle.
REQ-021 Back-to-back: a request held on valid_i SHALL be accepted on the edge ending the done_o cycle, giving 18-cycle throughput.
REQ-022 bcd_o and ovf_o SHALL hold their values between conversions; they SHALL NOT change during SHIFT.
REQ-023 done_o SHALL be 0 in every cycle other than the one following the FORMAT edge.
REQ-024 Boundary values: 0, 9999, 10000, and 65535 SHALL convert per REQ-016..019 with no wrap of scratch (20 bits holds 65535).

Reset
REQ-025 On rst_i=1, state SHALL go to IDLE asynchronously, with done_o=0 and ovf_o=0.
REQ-026 Reset value of bcd_o SHALL be 16'hFFF0 if BLANK_LEAD=1, else 16'h0000; scratch and counter SHALL clear.
REQ-027 Reset asserted mid-SHIFT or mid-FORMAT SHALL abort the conversion with no done_o pulse; ready_o=1 on the first cycle after release.

Verification
REQ-028 Reset, then idle 5 cycles -> ready_o=1, bcd_o=16'hFFF0 (BLANK_LEAD=1), done_o=0, ovf_o=0.
REQ-029 bin_i=16'd1234 with valid_i for one cycle -> ready_o=0 for 17 cycles; then done_o pulse, bcd_o=16'h1234, ovf_o=0.
REQ-030 BLANK_LEAD=1: inputs 0, 42, 1005 -> bcd_o 16'hFFF0, 16'hFF42, 16'h1005; BLANK_LEAD=0: input 42 -> 16'h0042.
REQ-031 Inputs 9999, 10000, 65535 -> 16'h9999/ovf_o=0, then 16'hFFFF/ovf_o=1, then 16'hFFFF/ovf_o=1.
REQ-032 valid_i held high with bin_i changed mid-conversion -> result reflects the value captured at acceptance; next request accepted exactly in the done_o cycle, with 18-cycle spacing between done_o pulses.
REQ-033 rst_i pulsed 8 cycles after acceptance -> no done_o pulse, bcd_o returns to its reset value, and a new request 1 cycle later completes normally.
